// File: rtl/ifs_bus_controller_if.sv
// Bus-state controller signal bundle between the interframe-space sequencer and the frame datapath.
// errorPassive exists only when SUSPEND_TRANSMISSION_EN is defined.
interface ifs_bus_controller_if;
  // No valid/ready pairs here: samplePoint, frameReady and endOverload are one-cycle
  // strobes acted on when high; txRequest is a level held until the txGrant pulse.
  logic       samplePoint;
  logic       canRX;
  logic       frameReady;
  logic       endOverload;
  logic       txRequest;
`ifdef SUSPEND_TRANSMISSION_EN
  logic       errorPassive;
`endif
  logic       isStart;
  logic       txGrant;
  logic       isOverload;
  logic       busIdle;
  logic       protocolError;
  logic [2:0] state;

  modport master (
    input  samplePoint, canRX, frameReady, endOverload, txRequest,
`ifdef SUSPEND_TRANSMISSION_EN
    input  errorPassive,
`endif
    output isStart, txGrant, isOverload, busIdle, protocolError, state
  );

  modport slave (
    output samplePoint, canRX, frameReady, endOverload, txRequest,
`ifdef SUSPEND_TRANSMISSION_EN
    output errorPassive,
`endif
    input  isStart, txGrant, isOverload, busIdle, protocolError, state
  );
endinterface

// File: rtl/ifs_bus_controller.sv
// CAN interframe-space bus-state controller: integration, idle, frame, intermission, overload.
// Optional suspend-transmission state enabled by defining SUSPEND_TRANSMISSION_EN.
module ifs_bus_controller #(
  parameter int INTEGRATION_BITS  = 11,
  parameter int INTERMISSION_BITS = 3,
  parameter int MAX_OVERLOAD      = 2,
  parameter int SUSPEND_BITS      = 8
) (
  input logic                  clock,
  input logic                  reset,
  ifs_bus_controller_if.master bus
);
  localparam int CW = $clog2(INTEGRATION_BITS + 1);
  localparam int OW = $clog2(MAX_OVERLOAD + 1);
  localparam logic [CW-1:0] INTEG_END = CW'(INTEGRATION_BITS);
  localparam logic [CW-1:0] INTER_END = CW'(INTERMISSION_BITS);
  localparam logic [CW-1:0] INTER_SOF = CW'(INTERMISSION_BITS - 1);
  localparam logic [OW-1:0] OVL_MAX   = OW'(MAX_OVERLOAD);
`ifdef SUSPEND_TRANSMISSION_EN
  localparam logic [CW-1:0] SUSP_END  = CW'(SUSPEND_BITS);
`endif

  typedef enum logic [2:0] {
    ST_INTEGRATING  = 3'd0,
    ST_IDLE         = 3'd1,
    ST_RECEIVING    = 3'd2,
    ST_INTERMISSION = 3'd3,
    ST_OVERLOAD     = 3'd4,
    ST_SUSPEND      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d, bit_inc;
  logic [OW-1:0] ovl_cnt_q, ovl_cnt_d;
  logic          tx_own_q, tx_own_d;
  logic          is_start_q, is_start_d;
  logic          tx_grant_q, tx_grant_d;
  logic          protocol_error_q, protocol_error_d;
  logic          is_overload_q, bus_idle_q;
  logic          rec, dom;

  assign rec     = bus.samplePoint & bus.canRX;
  assign dom     = bus.samplePoint & ~bus.canRX;
  assign bit_inc = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    ovl_cnt_d        = ovl_cnt_q;
    tx_own_d         = tx_own_q;
    is_start_d       = 1'b0;
    tx_grant_d       = 1'b0;
    protocol_error_d = 1'b0;
    case (state_q)
      ST_INTEGRATING: begin
        if (rec) begin
          if (bit_inc == INTEG_END) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_inc;
          end
        end else if (dom) begin
          bit_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        // A dominant bit from another node wins over our own pending request.
        if (dom) begin
          state_d    = ST_RECEIVING;
          is_start_d = 1'b1;
          tx_own_d   = 1'b0;
          ovl_cnt_d  = '0;
        end else if (rec && bus.txRequest) begin
          state_d    = ST_RECEIVING;
          is_start_d = 1'b1;
          tx_grant_d = 1'b1;
          tx_own_d   = 1'b1;
          ovl_cnt_d  = '0;
        end
      end
      ST_RECEIVING: begin
        if (bus.frameReady) begin
          state_d   = ST_INTERMISSION;
          bit_cnt_d = '0;
        end
      end
      ST_INTERMISSION: begin
        if (dom) begin
          if (bit_cnt_q == INTER_SOF) begin
            state_d    = ST_RECEIVING;
            is_start_d = 1'b1;
            tx_own_d   = 1'b0;
            ovl_cnt_d  = '0;
          end else if (ovl_cnt_q < OVL_MAX) begin
            state_d   = ST_OVERLOAD;
            ovl_cnt_d = ovl_cnt_q + 1'b1;
          end else begin
            state_d          = ST_INTEGRATING;
            bit_cnt_d        = '0;
            protocol_error_d = 1'b1;
          end
        end else if (rec) begin
          if (bit_inc == INTER_END) begin
            bit_cnt_d = '0;
            tx_own_d  = 1'b0;
            state_d   = ST_IDLE;
`ifdef SUSPEND_TRANSMISSION_EN
            if (tx_own_q && bus.errorPassive) state_d = ST_SUSPEND;
`endif
          end else begin
            bit_cnt_d = bit_inc;
          end
        end
      end
      ST_OVERLOAD: begin
        if (bus.endOverload) begin
          state_d   = ST_INTERMISSION;
          bit_cnt_d = '0;
        end
      end
`ifdef SUSPEND_TRANSMISSION_EN
      ST_SUSPEND: begin
        if (dom) begin
          state_d    = ST_RECEIVING;
          is_start_d = 1'b1;
          ovl_cnt_d  = '0;
        end else if (rec) begin
          if (bit_inc == SUSP_END) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_inc;
          end
        end
      end
`endif
      default: begin
        state_d   = ST_INTEGRATING;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_INTEGRATING;
      bit_cnt_q        <= '0;
      ovl_cnt_q        <= '0;
      tx_own_q         <= 1'b0;
      is_start_q       <= 1'b0;
      tx_grant_q       <= 1'b0;
      protocol_error_q <= 1'b0;
      is_overload_q    <= 1'b0;
      bus_idle_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      ovl_cnt_q        <= ovl_cnt_d;
      tx_own_q         <= tx_own_d;
      is_start_q       <= is_start_d;
      tx_grant_q       <= tx_grant_d;
      protocol_error_q <= protocol_error_d;
      is_overload_q    <= (state_d == ST_OVERLOAD);
      bus_idle_q       <= (state_d == ST_IDLE);
    end
  end

  assign bus.isStart       = is_start_q;
  assign bus.txGrant       = tx_grant_q;
  assign bus.isOverload    = is_overload_q;
  assign bus.busIdle       = bus_idle_q;
  assign bus.protocolError = protocol_error_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_ifs_bus_controller.sv
// Directed bench for ifs_bus_controller; the suspend scenario is built in when
// SUSPEND_TRANSMISSION_EN is defined.
module tb_ifs_bus_controller;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  ifs_bus_controller_if bus ();

  ifs_bus_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic idle_cycle();
    @(negedge clock);
    bus.samplePoint = 1'b0;
    bus.frameReady  = 1'b0;
    bus.endOverload = 1'b0;
  endtask

  task automatic sample_bit(input logic level);
    @(negedge clock);
    bus.samplePoint = 1'b1;
    bus.canRX       = level;
    @(negedge clock);
    bus.samplePoint = 1'b0;
    bus.canRX       = 1'b1;
  endtask

  task automatic sample_n(input int n, input logic level);
    for (int i = 0; i < n; i++) sample_bit(level);
  endtask

  task automatic pulse_frame_ready(input logic with_sample);
    @(negedge clock);
    bus.frameReady  = 1'b1;
    bus.samplePoint = with_sample;
    bus.canRX       = 1'b1;
    @(negedge clock);
    bus.frameReady  = 1'b0;
    bus.samplePoint = 1'b0;
  endtask

  task automatic pulse_end_overload();
    @(negedge clock);
    bus.endOverload = 1'b1;
    @(negedge clock);
    bus.endOverload = 1'b0;
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    n_cmp++;
    if ({bus.state, bus.busIdle, bus.isStart, bus.txGrant, bus.isOverload, bus.protocolError} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {bus.state, bus.busIdle, bus.isStart, bus.txGrant, bus.isOverload, bus.protocolError});
    end
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_integration();
    sample_n(10, 1'b1);
    chk("integ_after_10", bus.state, 3'd0);
    sample_bit(1'b0);
    sample_n(10, 1'b1);
    chk("integ_after_dominant_10", bus.state, 3'd0);
    chk("integ_busidle_low", {2'b00, bus.busIdle}, 3'd0);
    sample_bit(1'b1);
    chk("integ_state_idle", bus.state, 3'd1);
    chk("integ_busidle_high", {2'b00, bus.busIdle}, 3'd1);
    // dominant level without a samplePoint must be ignored
    @(negedge clock);
    bus.canRX = 1'b0;
    idle_cycle();
    bus.canRX = 1'b1;
    chk("idle_no_sample_ignored", bus.state, 3'd1);
  endtask

  task automatic test_tx_start();
    bus.txRequest = 1'b1;
    sample_bit(1'b1);
    chk("tx_isstart", {2'b00, bus.isStart}, 3'd1);
    chk("tx_txgrant", {2'b00, bus.txGrant}, 3'd1);
    chk("tx_state", bus.state, 3'd2);
    bus.txRequest = 1'b0;
    idle_cycle();
    chk("tx_pulse_width", {1'b0, bus.isStart, bus.txGrant}, 3'd0);
  endtask

  task automatic test_frame_end();
    // sample coinciding with frameReady does not count toward intermission
    pulse_frame_ready(1'b1);
    chk("fe_intermission", bus.state, 3'd3);
    sample_n(2, 1'b1);
    chk("fe_after_2", bus.state, 3'd3);
    sample_bit(1'b1);
    chk("fe_idle", bus.state, 3'd1);
    chk("fe_busidle", {2'b00, bus.busIdle}, 3'd1);
    chk("fe_no_start", {2'b00, bus.isStart}, 3'd0);
  endtask

  task automatic test_rx_start();
    bus.txRequest = 1'b1;
    sample_bit(1'b0);
    chk("rx_isstart", {2'b00, bus.isStart}, 3'd1);
    chk("rx_no_grant", {2'b00, bus.txGrant}, 3'd0);
    chk("rx_state", bus.state, 3'd2);
    bus.txRequest = 1'b0;
  endtask

  task automatic test_overload();
    pulse_frame_ready(1'b0);
    sample_bit(1'b0);
    chk("ovl1_state", bus.state, 3'd4);
    chk("ovl1_level", {2'b00, bus.isOverload}, 3'd1);
    pulse_frame_ready(1'b0);
    chk("ovl_ignores_frameready", bus.state, 3'd4);
    pulse_end_overload();
    chk("ovl1_exit", bus.state, 3'd3);
    sample_bit(1'b1);
    sample_bit(1'b0);
    chk("ovl2_state", bus.state, 3'd4);
    pulse_end_overload();
    sample_bit(1'b0);
    chk("ovl3_perr", {2'b00, bus.protocolError}, 3'd1);
    chk("ovl3_state", bus.state, 3'd0);
    chk("ovl3_level", {2'b00, bus.isOverload}, 3'd0);
    idle_cycle();
    chk("ovl3_perr_width", {2'b00, bus.protocolError}, 3'd0);
  endtask

  task automatic test_intermission_sof();
    sample_n(11, 1'b1);
    chk("sof_idle", bus.state, 3'd1);
    sample_bit(1'b0);
    pulse_frame_ready(1'b0);
    sample_bit(1'b0);
    chk("sof_pre_ovl", bus.state, 3'd4);
    pulse_end_overload();
    sample_n(2, 1'b1);
    sample_bit(1'b0);
    chk("sof_isstart", {2'b00, bus.isStart}, 3'd1);
    chk("sof_state", bus.state, 3'd2);
    chk("sof_no_overload", {1'b0, bus.isOverload, bus.txGrant}, 3'd0);
    // new frame restores the full overload allowance
    pulse_frame_ready(1'b0);
    sample_bit(1'b0);
    pulse_end_overload();
    sample_bit(1'b0);
    chk("sof_ovlcnt_cleared", bus.state, 3'd4);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rmid_state", bus.state, 3'd0);
    chk("rmid_outputs", {bus.busIdle, bus.isOverload, bus.isStart}, 3'd0);
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_own_tx_end();
    sample_n(11, 1'b1);
    bus.txRequest = 1'b1;
    sample_bit(1'b1);
    bus.txRequest = 1'b0;
    chk("own_granted", {2'b00, bus.txGrant}, 3'd1);
`ifdef SUSPEND_TRANSMISSION_EN
    bus.errorPassive = 1'b1;
    pulse_frame_ready(1'b0);
    sample_n(3, 1'b1);
    chk("susp_enter", bus.state, 3'd5);
    chk("susp_busidle_low", {2'b00, bus.busIdle}, 3'd0);
    bus.txRequest = 1'b1;
    sample_n(7, 1'b1);
    chk("susp_ignores_txreq", bus.state, 3'd5);
    bus.txRequest = 1'b0;
    sample_bit(1'b1);
    chk("susp_exit_idle", bus.state, 3'd1);
    chk("susp_busidle", {2'b00, bus.busIdle}, 3'd1);
    bus.errorPassive = 1'b0;
`else
    pulse_frame_ready(1'b0);
    sample_n(3, 1'b1);
    chk("own_end_idle", bus.state, 3'd1);
    chk("own_end_busidle", {2'b00, bus.busIdle}, 3'd1);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.samplePoint = 1'b0;
    bus.canRX       = 1'b1;
    bus.frameReady  = 1'b0;
    bus.endOverload = 1'b0;
    bus.txRequest   = 1'b0;
`ifdef SUSPEND_TRANSMISSION_EN
    bus.errorPassive = 1'b0;
`endif
    test_reset();
    test_integration();
    test_tx_start();
    test_frame_end();
    test_rx_start();
    test_overload();
    test_intermission_sof();
    test_reset_mid();
    test_own_tx_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
